// File: rtl/arith_pkg.sv
// Shared encodings for the arith_pipeline feeder: pipeline modes, job opcodes, FSM states.
package arith_pkg;

  localparam logic [1:0] MODE_EXP  = 2'd0;
  localparam logic [1:0] MODE_DIV  = 2'd1;
  localparam logic [1:0] MODE_GELU = 2'd2;
  localparam logic [1:0] MODE_AGG  = 2'd3;

  localparam logic [1:0] OP_SOFTMAX = 2'd0;
  localparam logic [1:0] OP_GELU    = 2'd1;
  localparam logic [1:0] OP_AGG     = 2'd2;
  localparam logic [1:0] OP_RSVD    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXP,
    S_DRAIN,
    S_DIV,
    S_GELU,
    S_AGG,
    S_DONE
  } feed_state_e;

  // First issue state for a job; reserved ops go straight to DONE.
  function automatic feed_state_e first_pass(input logic [1:0] op);
    case (op)
      OP_SOFTMAX: return S_EXP;
      OP_GELU:    return S_GELU;
      OP_AGG:     return S_AGG;
      default:    return S_DONE;
    endcase
  endfunction

  function automatic logic [1:0] pass_mode(input feed_state_e s);
    case (s)
      S_EXP:   return MODE_EXP;
      S_DIV:   return MODE_DIV;
      S_GELU:  return MODE_GELU;
      default: return MODE_AGG;
    endcase
  endfunction

endpackage

// File: rtl/arith_feed_buf.sv
// Vector buffer: DEPTH x {psum,data} register file, one write port, one combinational read port.
module arith_feed_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/arith_feeder.sv
// Transmit side of the arith_pipeline input: buffers one result vector, then replays it
// as registered beats in the mode order the job needs (exp, drain, div for softmax).
module arith_feeder
  import arith_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [15:0] wr_psum,
  input  logic        wr_last,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [15:0] out_psum,
  output logic [1:0]  out_mode,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned DCW = $clog2(DRAIN_CYC + 1);

  feed_state_e    state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic           out_valid_d;
  logic [15:0]    out_data_d, out_psum_d;
  logic [1:0]     out_mode_d;
  logic           wr_fire;
  logic [31:0]    rd_entry;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wr_ready  = (state_q == S_LOAD) && (count_q < CW'(DEPTH));
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && (op_q == OP_RSVD);
  assign wr_fire   = wr_valid && wr_ready;

  arith_feed_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (count_q[AW-1:0]),
    .wdata ({wr_psum, wr_data}),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      drain_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_psum  <= '0;
      out_mode  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      drain_q   <= drain_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_psum  <= out_psum_d;
      out_mode  <= out_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    drain_d     = drain_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_psum_d  = out_psum;
    out_mode_d  = out_mode;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          count_d  = '0;
          rd_ptr_d = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (wr_fire) begin
          count_d = count_q + 1'b1;
          if (wr_last || (count_q == CW'(DEPTH - 1))) begin
            state_d = first_pass(op_q);
            if (op_q != OP_RSVD) begin
              // Entry 0 is still being written on a 1-entry vector, so bypass the buffer.
              out_valid_d              = 1'b1;
              {out_psum_d, out_data_d} = (count_q == '0) ? {wr_psum, wr_data} : rd_entry;
              out_mode_d               = pass_mode(first_pass(op_q));
              rd_ptr_d                 = CW'(1);
            end
          end
        end
      end

      S_EXP, S_DIV, S_GELU, S_AGG: begin
        if (rd_ptr_q < count_q) begin
          out_valid_d              = 1'b1;
          {out_psum_d, out_data_d} = rd_entry;
          out_mode_d               = pass_mode(state_q);
          rd_ptr_d                 = rd_ptr_q + 1'b1;
        end else begin
          out_valid_d = 1'b0;
          rd_ptr_d    = '0;
          drain_d     = '0;
          state_d     = (state_q == S_EXP) ? S_DRAIN : S_DONE;
        end
      end

      S_DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYC - 1)) begin
          out_valid_d              = 1'b1;
          {out_psum_d, out_data_d} = rd_entry;
          out_mode_d               = MODE_DIV;
          rd_ptr_d                 = CW'(1);
          state_d                  = S_DIV;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_arith_feeder.sv
// Self-checking bench for arith_feeder: per-cycle schedule model plus literal spot checks.
module tb_arith_feeder;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned DRAIN_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        wr_valid, wr_ready, wr_last;
  logic [15:0] wr_data, wr_psum;
  logic        out_valid;
  logic [15:0] out_data, out_psum;
  logic [1:0]  out_mode;
  logic        busy, done, err;

  arith_feeder #(
    .DEPTH(DEPTH),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_psum(wr_psum), .wr_last(wr_last),
    .out_valid(out_valid), .out_data(out_data), .out_psum(out_psum),
    .out_mode(out_mode), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Expected DUT-visible state for one cycle; absent cycles mean "idle, nothing expected".
  typedef struct packed {
    logic        v;
    logic [1:0]  m;
    logic [15:0] p;
    logic [15:0] d;
    logic        done;
    logic        err;
    logic        busy;
    logic        wrr;
    logic        rst;
  } exp_t;

  exp_t        tab [int];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          idle_from = 1;
  bit          chk_en = 1'b0;
  logic [15:0] ent_d [16];
  logic [15:0] ent_p [16];
  logic [15:0] hd = '0, hp = '0;
  logic [1:0]  hm = '0;
  exp_t        ce;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  function automatic exp_t get_exp(input int c);
    if (tab.exists(c)) return tab[c];
    return '0;
  endfunction

  function automatic void set_beat(input int c, input logic [1:0] m,
                                   input logic [15:0] p, input logic [15:0] d);
    exp_t e;
    e = get_exp(c);
    e.v = 1'b1; e.m = m; e.p = p; e.d = d;
    tab[c] = e;
  endfunction

  function automatic void add_flags(input int c, input bit b, input bit w,
                                    input bit dn, input bit er, input bit rs);
    exp_t e;
    e = get_exp(c);
    e.busy = e.busy | b;
    e.wrr  = e.wrr | w;
    e.done = e.done | dn;
    e.err  = e.err | er;
    e.rst  = e.rst | rs;
    tab[c] = e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      ce = get_exp(cyc);
      if (ce.rst) begin hd = '0; hp = '0; hm = '0; end
      if (ce.v)   begin hd = ce.d; hp = ce.p; hm = ce.m; end
      chk("out_valid", 32'(out_valid), 32'(ce.v));
      chk("out_data",  32'(out_data),  32'(hd));
      chk("out_psum",  32'(out_psum),  32'(hp));
      chk("out_mode",  32'(out_mode),  32'(hm));
      chk("done",      32'(done),      32'(ce.done));
      chk("err",       32'(err),       32'(ce.err));
      chk("busy",      32'(busy),      32'(ce.busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(!ce.busy));
      chk("wr_ready",  32'(wr_ready),  32'(ce.wrr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  // Issues one job and records its full expected schedule before driving anything.
  task automatic run_job(input logic [1:0] op, input int nent, input int last_idx,
                         input int max_gap, output int f, output int dn);
    int e, n, k, de;
    int gap [16];
    e = (last_idx >= 0 && last_idx < int'(DEPTH)) ? last_idx : int'(DEPTH) - 1;
    n = e + 1;
    while (cyc < idle_from) step();
    k  = cyc;
    de = k;
    for (int i = 0; i < nent; i++) begin
      gap[i] = (i <= e) ? int'($urandom_range(32'(max_gap), 0)) : 0;
      if (i <= e) de += gap[i] + 1;
    end
    f = de + 1;
    for (int c = k + 1; c <= de; c++) add_flags(c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    case (op)
      2'd0: begin
        for (int j = 0; j < n; j++) begin
          set_beat(f + j, 2'd0, ent_p[j], ent_d[j]);
          set_beat(f + n + int'(DRAIN_CYC) + j, 2'd1, ent_p[j], ent_d[j]);
        end
        dn = f + 2 * n + int'(DRAIN_CYC);
      end
      2'd1, 2'd2: begin
        for (int j = 0; j < n; j++)
          set_beat(f + j, (op == 2'd1) ? 2'd2 : 2'd3, ent_p[j], ent_d[j]);
        dn = f + n;
      end
      default: dn = f;
    endcase
    for (int c = k + 1; c <= dn; c++) add_flags(c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_flags(dn, 1'b0, 1'b0, 1'b1, op == 2'd3, 1'b0);
    idle_from = dn + 1;

    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < nent; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        wr_valid = 1'b0; wr_last = 1'b0;
        step();
      end
      wr_valid = 1'b1;
      wr_data  = ent_d[i];
      wr_psum  = ent_p[i];
      wr_last  = (i == last_idx);
      step();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Asserts reset now; outputs read as reset for the next ncyc cycles, later expectations vanish.
  task automatic reset_begin(input int ncyc);
    int ks [$];
    int r;
    r = cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    foreach (tab[c]) if (c > r) ks.push_back(c);
    foreach (ks[i]) tab.delete(ks[i]);
    for (int c = r + 1; c <= r + ncyc; c++) add_flags(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_from = r + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, dn, r, op, li, ne;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0; wr_psum = '0;
    for (int c = 1; c <= 3; c++) add_flags(c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_en = 1'b1;
    at_cyc(1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    at_cyc(3);
    rst_n = 1'b1;

    // Softmax 3 entries; a held command during EXP must wait until after done.
    ent_d[0] = 16'h3C00; ent_d[1] = 16'h4000; ent_d[2] = 16'h4200;
    ent_p[0] = 16'h0001; ent_p[1] = 16'h0002; ent_p[2] = 16'h0003;
    run_job(2'd0, 3, 2, 0, f, dn);
    at_cyc(f);
    chk("smx_first_valid", 32'(out_valid), 32'd1);
    chk("smx_first_data",  32'(out_data),  32'h3C00);
    chk("smx_first_mode",  32'(out_mode),  32'd0);
    at_cyc(f + 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    at_cyc(f + 2);
    chk("smx_exp3_data", 32'(out_data), 32'h4200);
    at_cyc(f + 3);
    chk("smx_drain_valid", 32'(out_valid), 32'd0);
    at_cyc(f + 7);
    chk("smx_div0_valid", 32'(out_valid), 32'd1);
    chk("smx_div0_mode",  32'(out_mode),  32'd1);
    chk("smx_div0_data",  32'(out_data),  32'h3C00);
    at_cyc(f + 9);
    chk("smx_div2_data", 32'(out_data), 32'h4200);
    at_cyc(f + 10);
    chk("smx_done", 32'(done), 32'd1);
    chk("smx_err",  32'(err),  32'd0);

    // GeLU 8 entries, no wr_last; accepted from the held command.
    for (int i = 0; i < 8; i++) begin
      ent_d[i] = 16'h1000 + 16'(i);
      ent_p[i] = 16'h0000;
    end
    run_job(2'd1, 8, -1, 0, f, dn);
    at_cyc(f);
    chk("gelu_wr_ready_drop", 32'(wr_ready), 32'd0);
    chk("gelu_first_data", 32'(out_data), 32'h1000);
    chk("gelu_first_mode", 32'(out_mode), 32'd2);
    at_cyc(f + 7);
    chk("gelu_last_data", 32'(out_data), 32'h1007);
    at_cyc(f + 8);
    chk("gelu_done", 32'(done), 32'd1);
    chk("gelu_after_valid", 32'(out_valid), 32'd0);

    // AGG 2 entries with psum.
    ent_d[0] = 16'hAAAA; ent_d[1] = 16'hBBBB;
    ent_p[0] = 16'h1111; ent_p[1] = 16'h2222;
    run_job(2'd2, 2, 1, 1, f, dn);
    at_cyc(f);
    chk("agg_psum0", 32'(out_psum), 32'h1111);
    chk("agg_mode0", 32'(out_mode), 32'd3);
    at_cyc(f + 1);
    chk("agg_psum1", 32'(out_psum), 32'h2222);
    at_cyc(f + 2);
    chk("agg_done", 32'(done), 32'd1);

    // Reserved op: no beats, done and err together.
    ent_d[0] = 16'h5555; ent_p[0] = 16'h6666;
    run_job(2'd3, 1, 0, 0, f, dn);
    at_cyc(f);
    chk("rsvd_valid", 32'(out_valid), 32'd0);
    chk("rsvd_done",  32'(done),      32'd1);
    chk("rsvd_err",   32'(err),       32'd1);

    // Reset during the second DIV beat of a softmax job.
    for (int i = 0; i < 3; i++) begin
      ent_d[i] = 16'($urandom); ent_p[i] = 16'($urandom);
    end
    run_job(2'd0, 3, 2, 0, f, dn);
    at_cyc(f + 8);
    chk("rstmid_div1_valid", 32'(out_valid), 32'd1);
    chk("rstmid_div1_mode",  32'(out_mode),  32'd1);
    r = cyc;
    reset_begin(2);
    at_cyc(r + 1);
    chk("rstmid_valid",     32'(out_valid), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    at_cyc(r + 2);
    rst_n = 1'b1;

    // Randomized jobs, including over-long vectors and write gaps.
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(3, 0));
      if ($urandom_range(3, 0) == 0) begin
        li = -1;
        ne = int'(DEPTH) + int'($urandom_range(2, 0));
      end else begin
        li = int'($urandom_range(9, 0));
        ne = li + 1 + int'($urandom_range(1, 0));
      end
      for (int i = 0; i < ne; i++) begin
        ent_d[i] = 16'($urandom); ent_p[i] = 16'($urandom);
      end
      run_job(2'(op), ne, li, 2, f, dn);
      for (int g = 0; g < int'($urandom_range(3, 0)); g++) step();
    end

    at_cyc(idle_from + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
